// File: rtl/pixel_out_stage_if.sv
// Video stream bundle for pixel_out_stage: the incoming pixel/sync/blank
// stream with its column count, and the registered stream leaving the stage.
interface pixel_out_stage_if;
  logic [23:0] pixel_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  logic [10:0] hcount;
  logic [23:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;

  // Source side: produces the incoming stream, consumes the output stream.
  modport master (
    output pixel_in, hsync_in, vsync_in, blank_in, hcount,
    input  rgb_out, hsync_out, vsync_out, blank_out
  );

  // Stage side: consumes the incoming stream, produces the output stream.
  modport slave (
    input  pixel_in, hsync_in, vsync_in, blank_in, hcount,
    output rgb_out, hsync_out, vsync_out, blank_out
  );
endinterface

// File: rtl/pixel_out_stage.sv
// pixel_out_stage: final video output stage.
//  - Two-register pixel/sync/blank pipeline; blanked pixels are forced black.
//  - Shift sequencer: counts vsync frames and emits a one-clock shft pulse
//    every FRAMES_PER_SHIFT frames, with step_count/shft_rst tracking the
//    position inside a SHIFT_STEPS-long colour cycle.
// Optional feature: define PIXEL_OUT_TESTBAR_EN to let test_mode replace the
// stage-1 pixel with 8 vertical colour bars selected by hcount[9:7].
module pixel_out_stage #(
  parameter int FRAMES_PER_SHIFT = 4,   // 1..255
  parameter int SHIFT_STEPS      = 32   // 1..256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 test_mode,
  pixel_out_stage_if.slave     vid,
  output logic                 shft,
  output logic                 shft_rst,
  output logic [7:0]           step_count
);

  localparam logic [8:0] FRAMES_TARGET = 9'(FRAMES_PER_SHIFT);
  localparam logic [7:0] LAST_STEP     = 8'(SHIFT_STEPS - 1);
  localparam logic       SHFT_RST_INIT = (SHIFT_STEPS == 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PULSE   = 2'd2,
    ADVANCE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Pixel path
  // ---------------------------------------------------------------------------
  logic [23:0] stage1_pixel_d;
  logic [23:0] stage1_pixel;
  logic        stage1_hsync;
  logic        stage1_vsync;
  logic        stage1_blank;

`ifdef PIXEL_OUT_TESTBAR_EN
  logic [2:0]  bar_index;
  logic [23:0] bar_pixel;
  logic        unused_hcount_bits;

  assign bar_index = vid.hcount[9:7];
  assign bar_pixel = {{8{bar_index[2]}}, {8{bar_index[1]}}, {8{bar_index[0]}}};
  assign unused_hcount_bits = ^{vid.hcount[10], vid.hcount[6:0]};

  // Colour bars override the incoming pixel; blanking still applies later.
  always_comb begin
    stage1_pixel_d = test_mode ? bar_pixel : vid.pixel_in;
  end
`else
  logic unused_testbar_inputs;

  assign unused_testbar_inputs = ^{test_mode, vid.hcount};

  // Without the test-bar feature the incoming pixel passes straight through.
  always_comb begin
    stage1_pixel_d = vid.pixel_in;
  end
`endif

  // Stage 1: capture pixel, syncs and blank together.
  // NOTE: every flop here, including pure pipeline data, is reset so the output
  // idles black/blanked with inactive syncs rather than showing stale garbage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage1_pixel <= 24'h000000;
      stage1_hsync <= 1'b1;
      stage1_vsync <= 1'b1;
      stage1_blank <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      stage1_pixel <= stage1_pixel_d;
      stage1_hsync <= vid.hsync_in;
      stage1_vsync <= vid.vsync_in;
      stage1_blank <= vid.blank_in;
    end
  end

  // Stage 2: apply blanking and drive the registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid.rgb_out   <= 24'h000000;
      vid.hsync_out <= 1'b1;
      vid.vsync_out <= 1'b1;
      vid.blank_out <= 1'b1;
    end else begin
      vid.rgb_out   <= stage1_blank ? 24'h000000 : stage1_pixel;
      vid.hsync_out <= stage1_hsync;
      vid.vsync_out <= stage1_vsync;
      vid.blank_out <= stage1_blank;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift sequencer
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] step_count_d;
  logic       vsync_q;
  logic       frame_edge;
  logic [8:0] frame_sum;
  logic [7:0] frame_sum_sat;

  // One frame event per falling vsync edge, seen against the registered copy.
  assign frame_edge    = vsync_q & ~vid.vsync_in;
  assign frame_sum     = {1'b0, frame_cnt_q} + {8'd0, frame_edge};
  assign frame_sum_sat = frame_sum[8] ? 8'hFF : frame_sum[7:0];

  // Next-state, frame counter and step counter decode.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    step_count_d = step_count;
    unique case (state_q)
      IDLE: begin
        frame_cnt_d = 8'd0;
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_d     = IDLE;
          frame_cnt_d = 8'd0;
        end else if (frame_sum >= FRAMES_TARGET) begin
          // Any frames that arrived during the last PULSE/ADVANCE carry over.
          state_d     = PULSE;
          frame_cnt_d = 8'(frame_sum - FRAMES_TARGET);
        end else begin
          frame_cnt_d = frame_sum[7:0];
        end
      end
      PULSE: begin
        state_d     = ADVANCE;
        frame_cnt_d = frame_sum_sat;
      end
      ADVANCE: begin
        step_count_d = (step_count == LAST_STEP) ? 8'd0 : step_count + 8'd1;
        if (enable) begin
          state_d     = COUNT;
          frame_cnt_d = frame_sum_sat;
        end else begin
          state_d     = IDLE;
          frame_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        frame_cnt_d = 8'd0;
      end
    endcase
  end

  // Sequencer registers; shft and shft_rst come straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      step_count  <= 8'd0;
      shft        <= 1'b0;
      shft_rst    <= SHFT_RST_INIT;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      step_count  <= step_count_d;
      shft        <= (state_d == PULSE);
      shft_rst    <= (step_count_d == LAST_STEP);
      vsync_q     <= vid.vsync_in;
    end
  end

endmodule

// File: tb/tb_pixel_out_stage.sv
// Directed testbench for pixel_out_stage. Two instances share clock, reset
// and video stimulus: dut_a uses default parameters, dut_b uses
// SHIFT_STEPS=3, FRAMES_PER_SHIFT=1 for the colour-cycle wrap case.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_pixel_out_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic       test_mode = 1'b0;
  logic       shft_a, shft_rst_a, shft_b, shft_rst_b;
  logic [7:0] step_a, step_b;

  int errors = 0;
  int checks = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  pixel_out_stage_if vid_a ();
  pixel_out_stage_if vid_b ();

  pixel_out_stage dut_a (
    .clk        (clk),
    .reset_n    (rst_n),
    .enable     (en_a),
    .test_mode  (test_mode),
    .vid        (vid_a.slave),
    .shft       (shft_a),
    .shft_rst   (shft_rst_a),
    .step_count (step_a)
  );

  pixel_out_stage #(.FRAMES_PER_SHIFT(1), .SHIFT_STEPS(3)) dut_b (
    .clk        (clk),
    .reset_n    (rst_n),
    .enable     (en_b),
    .test_mode  (test_mode),
    .vid        (vid_b.slave),
    .shft       (shft_b),
    .shft_rst   (shft_rst_b),
    .step_count (step_b)
  );

  always #5 clk = ~clk;

  // Count shft pulses; each pulse spans exactly one falling edge.
  always @(negedge clk) begin
    if (shft_a) pulses_a = pulses_a + 1;
    if (shft_b) pulses_b = pulses_b + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] pix, input logic hs, input logic vs,
                       input logic bl, input logic [10:0] hc);
    vid_a.pixel_in = pix; vid_a.hsync_in = hs; vid_a.vsync_in = vs;
    vid_a.blank_in = bl;  vid_a.hcount = hc;
    vid_b.pixel_in = pix; vid_b.hsync_in = hs; vid_b.vsync_in = vs;
    vid_b.blank_in = bl;  vid_b.hcount = hc;
  endtask

  task automatic set_vsync(input logic vs);
    vid_a.vsync_in = vs;
    vid_b.vsync_in = vs;
  endtask

  task automatic test_reset();
    drive(24'h5A5A5A, 1'b0, 1'b1, 1'b0, 11'd0);
    #12;
    checks++; if (vid_a.rgb_out !== 24'h000000) begin errors++; $display("FAIL reset_rgb: got %h expected 000000", vid_a.rgb_out); end
    checks++; if ({vid_a.hsync_out, vid_a.vsync_out, vid_a.blank_out} !== 3'b111) begin errors++; $display("FAIL reset_syncs: got %b expected 111", {vid_a.hsync_out, vid_a.vsync_out, vid_a.blank_out}); end
    checks++; if (shft_a !== 1'b0 || step_a !== 8'd0 || shft_rst_a !== 1'b0) begin errors++; $display("FAIL reset_seq_a: shft=%b step=%0d shft_rst=%b expected 0/0/0", shft_a, step_a, shft_rst_a); end
    checks++; if (shft_b !== 1'b0 || step_b !== 8'd0 || shft_rst_b !== 1'b0) begin errors++; $display("FAIL reset_seq_b: shft=%b step=%0d shft_rst=%b expected 0/0/0", shft_b, step_b, shft_rst_b); end
    rst_n = 1'b1;
    drive(24'h000000, 1'b1, 1'b1, 1'b1, 11'd0);
    tick(); tick();
  endtask

  task automatic test_pixel_path();
    drive(24'hA1B2C3, 1'b0, 1'b0, 1'b0, 11'd100);
    tick();
    checks++; if (vid_a.hsync_out !== 1'b1 || vid_a.rgb_out !== 24'h000000) begin errors++; $display("FAIL pix_delay1: hsync=%b rgb=%h expected 1/000000", vid_a.hsync_out, vid_a.rgb_out); end
    tick();
    checks++; if (vid_a.rgb_out !== 24'hA1B2C3) begin errors++; $display("FAIL pix_delay2_rgb: got %h expected A1B2C3", vid_a.rgb_out); end
    checks++; if ({vid_a.hsync_out, vid_a.vsync_out, vid_a.blank_out} !== 3'b000) begin errors++; $display("FAIL pix_delay2_syncs: got %b expected 000", {vid_a.hsync_out, vid_a.vsync_out, vid_a.blank_out}); end
    drive(24'hA1B2C3, 1'b1, 1'b1, 1'b0, 11'd101);
    tick();
    checks++; if (vid_a.hsync_out !== 1'b0) begin errors++; $display("FAIL sync_rise_delay1: got %b expected 0", vid_a.hsync_out); end
    tick();
    checks++; if ({vid_a.hsync_out, vid_a.vsync_out} !== 2'b11) begin errors++; $display("FAIL sync_rise_delay2: got %b expected 11", {vid_a.hsync_out, vid_a.vsync_out}); end
  endtask

  task automatic test_blanking();
    drive(24'hFFFFFF, 1'b1, 1'b1, 1'b1, 11'd102);
    tick();
    checks++; if (vid_a.rgb_out !== 24'hA1B2C3 || vid_a.blank_out !== 1'b0) begin errors++; $display("FAIL blank_delay1: rgb=%h blank=%b expected A1B2C3/0", vid_a.rgb_out, vid_a.blank_out); end
    tick();
    checks++; if (vid_a.rgb_out !== 24'h000000 || vid_a.blank_out !== 1'b1) begin errors++; $display("FAIL blank_delay2: rgb=%h blank=%b expected 000000/1", vid_a.rgb_out, vid_a.blank_out); end
  endtask

  task automatic test_testbar();
    test_mode = 1'b1;
    drive(24'h123456, 1'b1, 1'b1, 1'b0, 11'd640);
    tick(); tick();
`ifdef PIXEL_OUT_TESTBAR_EN
    checks++; if (vid_a.rgb_out !== 24'hFF00FF) begin errors++; $display("FAIL testbar_k5: got %h expected FF00FF", vid_a.rgb_out); end
`else
    checks++; if (vid_a.rgb_out !== 24'h123456) begin errors++; $display("FAIL testmode_ignored: got %h expected 123456", vid_a.rgb_out); end
`endif
    drive(24'h123456, 1'b1, 1'b1, 1'b1, 11'd640);
    tick(); tick();
    checks++; if (vid_a.rgb_out !== 24'h000000) begin errors++; $display("FAIL testmode_blank: got %h expected 000000", vid_a.rgb_out); end
    test_mode = 1'b0;
    drive(24'h000000, 1'b1, 1'b1, 1'b1, 11'd0);
    tick();
  endtask

  task automatic test_shift_sequence();
    int base;
    en_a = 1'b1;
    tick();
    base = pulses_a;
    for (int i = 0; i < 12; i++) begin
      set_vsync(1'b0);
      tick();
      checks++; if (shft_a !== (i % 4 == 3)) begin errors++; $display("FAIL seq_pulse_edge%0d: got %b expected %b", i + 1, shft_a, (i % 4 == 3)); end
      set_vsync(1'b1);
      tick();
      checks++; if (shft_a !== 1'b0) begin errors++; $display("FAIL seq_pulse_width_edge%0d: got %b expected 0", i + 1, shft_a); end
      tick(); tick();
    end
    checks++; if (pulses_a - base !== 3) begin errors++; $display("FAIL seq_pulse_count: got %0d expected 3", pulses_a - base); end
    checks++; if (step_a !== 8'd3 || shft_rst_a !== 1'b0) begin errors++; $display("FAIL seq_step: step=%0d shft_rst=%b expected 3/0", step_a, shft_rst_a); end
    // Drop enable while counting: step_count must be kept.
    en_a = 1'b0;
    tick(); tick();
    checks++; if (step_a !== 8'd3) begin errors++; $display("FAIL disable_in_count_step: got %0d expected 3", step_a); end
  endtask

  task automatic test_shift_wrap();
    int base_a;
    base_a = pulses_a;
    en_b = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (shft_rst_b !== (i == 2)) begin errors++; $display("FAIL wrap_rst_before%0d: got %b expected %b", i + 1, shft_rst_b, (i == 2)); end
      set_vsync(1'b0);
      tick();
      checks++; if (shft_b !== 1'b1 || shft_rst_b !== (i == 2)) begin errors++; $display("FAIL wrap_pulse%0d: shft=%b shft_rst=%b expected 1/%b", i + 1, shft_b, shft_rst_b, (i == 2)); end
      set_vsync(1'b1);
      tick(); tick();
      checks++; if (step_b !== 8'((i + 1) % 3)) begin errors++; $display("FAIL wrap_step%0d: got %0d expected %0d", i + 1, step_b, (i + 1) % 3); end
      tick();
    end
    checks++; if (shft_rst_b !== 1'b0) begin errors++; $display("FAIL wrap_rst_after: got %b expected 0", shft_rst_b); end
    checks++; if (pulses_a !== base_a) begin errors++; $display("FAIL idle_no_pulse_a: got %0d pulses expected 0", pulses_a - base_a); end
    en_b = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop_in_pulse();
    int base;
    en_a = 1'b1;
    tick();
    base = pulses_a;
    for (int i = 0; i < 4; i++) begin
      set_vsync(1'b0);
      tick();
      if (i == 3) begin
        checks++; if (shft_a !== 1'b1) begin errors++; $display("FAIL drop_pulse_seen: got %b expected 1", shft_a); end
        en_a = 1'b0;
      end
      set_vsync(1'b1);
      tick();
      if (i == 3) begin
        checks++; if (shft_a !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: got %b expected 0", shft_a); end
      end
      tick(); tick();
    end
    checks++; if (step_a !== 8'd4) begin errors++; $display("FAIL drop_step: got %0d expected 4", step_a); end
    for (int i = 0; i < 4; i++) begin
      set_vsync(1'b0); tick();
      set_vsync(1'b1); tick(); tick(); tick();
    end
    checks++; if (pulses_a - base !== 1 || step_a !== 8'd4) begin errors++; $display("FAIL drop_then_idle: pulses=%0d step=%0d expected 1/4", pulses_a - base, step_a); end
  endtask

  task automatic test_reset_mid_pulse();
    en_b = 1'b1;
    drive(24'h123456, 1'b0, 1'b1, 1'b0, 11'd5);
    tick(); tick();
    set_vsync(1'b0);
    tick();
    checks++; if (shft_b !== 1'b1 || vid_b.rgb_out !== 24'h123456 || vid_b.hsync_out !== 1'b0) begin errors++; $display("FAIL pre_reset: shft=%b rgb=%h hsync=%b expected 1/123456/0", shft_b, vid_b.rgb_out, vid_b.hsync_out); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (shft_b !== 1'b0 || step_b !== 8'd0 || shft_rst_b !== 1'b0) begin errors++; $display("FAIL async_reset_seq: shft=%b step=%0d shft_rst=%b expected 0/0/0", shft_b, step_b, shft_rst_b); end
    checks++; if (vid_b.rgb_out !== 24'h000000 || {vid_b.hsync_out, vid_b.vsync_out, vid_b.blank_out} !== 3'b111) begin errors++; $display("FAIL async_reset_pix: rgb=%h syncs=%b expected 000000/111", vid_b.rgb_out, {vid_b.hsync_out, vid_b.vsync_out, vid_b.blank_out}); end
    checks++; if (step_a !== 8'd0) begin errors++; $display("FAIL async_reset_step_a: got %0d expected 0", step_a); end
    set_vsync(1'b1);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (shft_b !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: got %b expected 0", shft_b); end
    set_vsync(1'b0);
    tick();
    checks++; if (shft_b !== 1'b1) begin errors++; $display("FAIL post_reset_restart: got %b expected 1", shft_b); end
    set_vsync(1'b1);
    tick(); tick();
    checks++; if (step_b !== 8'd1) begin errors++; $display("FAIL post_reset_step: got %0d expected 1", step_b); end
  endtask

  initial begin
    test_reset();
    test_pixel_path();
    test_blanking();
    test_testbar();
    test_shift_sequence();
    test_shift_wrap();
    test_enable_drop_in_pulse();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_out_stage.md
PIXEL_OUT_STAGE -- requirements
Module: pixel_out_stage

Interface
REQ-001 Parameter FRAMES_PER_SHIFT, default 4: vsync frames between shft pulses; legal range 1..255.
REQ-002 Parameter SHIFT_STEPS, default 32: shft pulses per colour cycle before shft_rst; legal range 1..256.
REQ-003 clk  in  1  single pixel clock; all flops on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 enable  in  1  high = shift sequencer runs.
REQ-006 pixel_in  in  24  {R,G,B} from colour-shift stage, combinational relative to hcount.
REQ-007 hsync_in, vsync_in  in  1 each  active-low syncs aligned with pixel_in.
REQ-008 blank_in  in  1  high = outside active video.
REQ-009 hcount  in  11  current pixel column.
REQ-010 test_mode  in  1  colour-bar select; used only per REQ-031.
REQ-011 rgb_out  out  24  registered output pixel.
REQ-012 hsync_out, vsync_out, blank_out  out  1 each  registered, delay-matched to rgb_out.
REQ-013 shft  out  1  one-clock high pulse advancing the colour-shift stage.
REQ-014 shft_rst  out  1  level; high = colour-shift stage resets on next shft edge.
REQ-015 step_count  out  8  shft pulses issued in current colour cycle.

Function
REQ-016 Pixel path: two register stages; rgb_out/hsync_out/vsync_out/blank_out = inputs delayed exactly 2 clocks.
REQ-017 Stage 2: rgb_out = 24'h000000 when delayed blank is 1, else delayed pixel.
REQ-018 Frame boundary = falling edge of vsync_in, detected against a registered copy (reset value 1); one event per edge.
REQ-019 States: IDLE, COUNT, PULSE, ADVANCE; reset state IDLE.
REQ-020 IDLE: frame counter held 0, shft 0; enable=1 -> COUNT next clock.
REQ-021 COUNT: each frame boundary increments the 8-bit frame counter; on the boundary that makes it equal FRAMES_PER_SHIFT, counter clears, -> PULSE.
REQ-022 PULSE: shft=1 for exactly this one clock; -> ADVANCE unconditionally.
REQ-023 ADVANCE: shft=0; step_count increments, or wraps to 0 when equal SHIFT_STEPS-1; -> COUNT if enable, else IDLE.
REQ-024 shft_rst = (step_count == SHIFT_STEPS-1), registered; stable throughout the PULSE clock and the clock before, since step_count changes only in ADVANCE.
REQ-025 enable falling in COUNT -> IDLE next clock, frame counter cleared; step_count retained.
REQ-026 enable falling in PULSE -> pulse completes, ADVANCE runs, then IDLE.
REQ-027 Frame boundaries in PULSE/ADVANCE are counted toward the next period, never lost.
REQ-028 shft is driven directly from a flop, glitch-free.

Reset
REQ-029 reset_n low, asynchronously: rgb_out 0, hsync_out 1, vsync_out 1, blank_out 1, shft 0, step_count 0, shft_rst = (SHIFT_STEPS==1), frame counter 0, state IDLE, pipeline flops at those values.
REQ-030 Reset mid-PULSE clears shft immediately; sequence restarts from IDLE after release.

Configuration
REQ-031 Macro PIXEL_OUT_TESTBAR_EN defined: test_mode=1 replaces stage-1 pixel with bar k=hcount[9:7], R=k[2]?FF:00, G=k[1]?FF:00, B=k[0]?FF:00; blanking still applies. Undefined: test_mode ignored, pixel path per REQ-016/017 only.

Verification
REQ-032 pixel_in=24'hA1B2C3, blank_in=0, syncs toggled at clock t -> rgb_out=A1B2C3, sync edges at t+2.
REQ-033 blank_in=1 with pixel_in=24'hFFFFFF -> rgb_out=000000, blank_out=1, two clocks later.
REQ-034 FRAMES_PER_SHIFT=4, enable=1, 12 vsync falling edges -> 3 single-clock shft pulses, each one clock after the 4th/8th/12th edge's detection; step_count 0->3.
REQ-035 SHIFT_STEPS=3, FRAMES_PER_SHIFT=1 -> shft_rst high before and during 3rd pulse, step_count wraps 2->0.
REQ-036 enable dropped in PULSE -> that pulse is 1 clock, step_count increments once, then IDLE with no further pulses; reset_n pulsed low mid-frame -> all outputs at REQ-029 values same cycle.
REQ-037 With PIXEL_OUT_TESTBAR_EN, test_mode=1, hcount=11'd640 (k=5) -> rgb_out=FF00FF.
